multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS variant. It sequences one shared ALU, the instruction register, the PC and a single memory port over several cycles per instruction.
- It drives the 2-bit Aluop consumed by the ALU control decoder:
  - 2'b11 = add
  - 2'b01 = subtract
  - 2'b00 = R-type, function field decides
- It waits on a memory-ready handshake, so fetch and data accesses tolerate variable-latency memory.

Parameters:
- MAX_WAIT, 15, maximum cycles spent waiting for mem_ready in any one memory state before the instruction is aborted with a timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  6  IR[31:26]; sampled in DECODE.
- Zero  in  1  ALU zero flag; valid in BRANCH.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- Aluop  out  2  to the ALU control decoder.
- AluSrcA  out  1  0 = PC, 1 = register A.
- AluSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- PCWrite  out  1  load PC from ALU result.
- PCWriteBr  out  1  load PC from ALUOut (branch target).
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load the instruction register.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- timeout  out  1  one-cycle pulse when MAX_WAIT expires.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FETCH and the wait counter clears.
  - Every output is 0 while reset is asserted, including Aluop=2'b00.
  - The first FETCH outputs appear on the first cycle after rst_n deasserts.
- Outputs are decoded combinationally from the state register, with two exceptions:
  - PCWriteBr = (state==BRANCH) & Zero.
  - PCWrite in FETCH = mem_ready.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, EXEC_I=9, I_WB=10.
- FETCH:
  - Drives MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, Aluop=11.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1. That cycle moves to DECODE; otherwise stay in FETCH.
- DECODE:
  - Drives AluSrcA=0, AluSrcB=11, Aluop=11 to precompute the branch target.
  - Next state by Opcode:
    - 000000 goes to EXEC_R.
    - 100011 (lw) and 101011 (sw) go to MEM_ADDR.
    - 000100 (beq) goes to BRANCH.
    - 001000 (addi) goes to EXEC_I.
    - Any other opcode pulses illegal=1 and goes to FETCH, with no register or memory side effect.
- MEM_ADDR: drives AluSrcA=1, AluSrcB=10, Aluop=11. lw goes to MEM_RD, sw goes to MEM_WR; the opcode is held in a register latched in DECODE.
- MEM_RD: drives MemRead=1, IorD=1. Stays until mem_ready=1, then goes to MEM_WB.
- MEM_WB: drives RegWrite=1, RegDst=0, MemtoReg=1, then goes to FETCH.
- MEM_WR: drives MemWrite=1, IorD=1. Stays until mem_ready=1, then goes to FETCH.
- EXEC_R: drives AluSrcA=1, AluSrcB=00, Aluop=00, then goes to R_WB.
- R_WB: drives RegWrite=1, RegDst=1, MemtoReg=0, then goes to FETCH.
- BRANCH: drives AluSrcA=1, AluSrcB=00, Aluop=01, then goes to FETCH.
- EXEC_I: drives AluSrcA=1, AluSrcB=10, Aluop=11, then goes to I_WB.
- I_WB: drives RegWrite=1, RegDst=0, MemtoReg=0, then goes to FETCH.
- Unused encodings 11–15 go to FETCH on the next edge with all outputs 0.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on each cycle spent in one of those states with mem_ready=0.
  - If the counter equals MAX_WAIT while mem_ready=0: pulse timeout=1, go to FETCH, and drop the request the next cycle. PC, IR and the register file are not written.
  - mem_ready=1 in the same cycle the counter hits MAX_WAIT counts as success, with no timeout.
- Latency per instruction with zero-wait memory:
  - R-type, addi, sw: 4 cycles.
  - beq: 3 cycles.
  - lw: 5 cycles.
- Each mem_ready wait cycle adds 1 cycle.
- Reset asserted mid-instruction aborts it immediately. Any pending write enable drops asynchronously.

Test Plan:
- Reset, then an R-type (Opcode=0) with mem_ready tied 1: states 0→1→6→7→0. Aluop reads 11, 11, 00, then 0 in R_WB. RegWrite=1 with RegDst=1 only in R_WB.
- lw (100011) with mem_ready low 3 cycles in MEM_RD: MEM_RD held 3 extra cycles. RegWrite=1 with MemtoReg=1 exactly once. Total 8 cycles.
- beq (000100): with Zero=1, PCWriteBr=1 in BRANCH and Aluop=01. Repeated with Zero=0: PCWriteBr stays 0 and the FSM returns to FETCH after 3 cycles.
- Opcode=6'b111111: illegal pulses 1 cycle in DECODE, next state is FETCH, and RegWrite, MemWrite and PCWriteBr are never asserted.
- mem_ready held 0 in FETCH with MAX_WAIT=15: timeout pulses on wait cycle 15, the FSM re-enters FETCH, and IRWrite and PCWrite are never asserted.
- rst_n dropped in MEM_WR while MemWrite=1: MemWrite falls without a clock edge, and FETCH resumes on the first edge after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences ALU, IR, PC and one memory port; waits on mem_ready with a timeout.
module multicycle_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [1:0] Aluop,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic       PCWrite,
    output logic       PCWriteBr,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10
    } state_t;

    state_t        r_state;
    logic          r_is_sw;
    logic [CW-1:0] r_cnt;
    logic          w_wait_st;
    logic          w_timeout;
    logic          w_legal;

    assign w_wait_st = (r_state == FETCH) || (r_state == MEM_RD) ||
                       (r_state == MEM_WR);
    assign w_timeout = w_wait_st && !mem_ready && (r_cnt == CW'(MAX_WAIT));
    assign w_legal   = (Opcode == 6'b000000) || (Opcode == 6'b100011) ||
                       (Opcode == 6'b101011) || (Opcode == 6'b000100) ||
                       (Opcode == 6'b001000);
    assign state_o   = r_state;

    // Counter is zeroed in every non-waiting state so each wait state starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_is_sw <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_state <= DECODE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    r_cnt   <= '0;
                    r_is_sw <= (Opcode == 6'b101011);
                    case (Opcode)
                        6'b000000: r_state <= EXEC_R;
                        6'b100011: r_state <= MEM_ADDR;
                        6'b101011: r_state <= MEM_ADDR;
                        6'b000100: r_state <= BRANCH;
                        6'b001000: r_state <= EXEC_I;
                        default:   r_state <= FETCH;
                    endcase
                end
                MEM_ADDR: begin
                    r_cnt   <= '0;
                    r_state <= r_is_sw ? MEM_WR : MEM_RD;
                end
                MEM_RD, MEM_WR: begin
                    if (mem_ready) begin
                        r_state <= (r_state == MEM_RD) ? MEM_WB : FETCH;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXEC_R: begin
                    r_cnt   <= '0;
                    r_state <= R_WB;
                end
                EXEC_I: begin
                    r_cnt   <= '0;
                    r_state <= I_WB;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // Gating with rst_n makes every enable drop the moment reset asserts.
    always_comb begin
        Aluop     = 2'b00;
        AluSrcA   = 1'b0;
        AluSrcB   = 2'b00;
        PCWrite   = 1'b0;
        PCWriteBr = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        illegal   = 1'b0;
        timeout   = 1'b0;
        if (rst_n) begin
            timeout = w_timeout;
            case (r_state)
                FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = 2'b01;
                    Aluop   = 2'b11;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    AluSrcB = 2'b11;
                    Aluop   = 2'b11;
                    illegal = !w_legal;
                end
                MEM_ADDR, EXEC_I: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    Aluop   = 2'b11;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC_R: begin
                    AluSrcA = 1'b1;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    AluSrcA   = 1'b1;
                    Aluop     = 2'b01;
                    PCWriteBr = Zero;
                end
                I_WB: begin
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic [1:0] Aluop;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic       PCWrite;
    logic       PCWriteBr;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       illegal;
    logic       timeout;
    logic [3:0] state_o;

    int n_pass;
    int n_total;

    multicycle_control #(.MAX_WAIT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .Aluop     (Aluop),
        .AluSrcA   (AluSrcA),
        .AluSrcB   (AluSrcB),
        .PCWrite   (PCWrite),
        .PCWriteBr (PCWriteBr),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .illegal   (illegal),
        .timeout   (timeout),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [20:0] w_outs = {Aluop, AluSrcA, AluSrcB, PCWrite, PCWriteBr, IorD,
                          MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                          MemtoReg, illegal, timeout, state_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, tallying events.
    task automatic run_instr(input logic [5:0] op, input logic z,
                             input int waits, output int cyc, output int n_rw,
                             output int n_m2r, output int n_mw,
                             output int n_br, output int n_to);
        int w;
        w = 0; cyc = 0; n_rw = 0; n_m2r = 0; n_mw = 0; n_br = 0; n_to = 0;
        Opcode = op;
        Zero   = z;
        do begin
            mem_ready = 1'b1;
            if ((state_o == 4'd3 || state_o == 4'd5) && w < waits) begin
                mem_ready = 1'b0;
                w++;
            end
            #1;
            n_rw  += int'(RegWrite);
            n_m2r += int'(RegWrite && MemtoReg);
            n_mw  += int'(MemWrite);
            n_br  += int'(PCWriteBr);
            n_to  += int'(timeout);
            @(posedge clk);
            #1;
            cyc++;
        end while (state_o != 4'd0 && cyc < 60);
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; Opcode = 6'd0; Zero = 1'b0;
        #12;
        n_total++;
        if (w_outs !== 21'd0)
            $display("FAIL reset_outs: got %h want 0", w_outs);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({MemRead, IorD, AluSrcA, AluSrcB, Aluop, state_o} !== 11'b1_0_0_01_11_0000)
            $display("FAIL reset_fetch: got %b want 10001110000",
                     {MemRead, IorD, AluSrcA, AluSrcB, Aluop, state_o});
        else n_pass++;
        step();
    endtask

    task automatic test_rtype();
        Opcode = 6'b000000; mem_ready = 1'b1;
        #1;
        n_total++;
        if ({state_o, Aluop, IRWrite, PCWrite} !== 8'b0000_11_1_1)
            $display("FAIL r_fetch: got %b want 00001111",
                     {state_o, Aluop, IRWrite, PCWrite});
        else n_pass++;
        step();
        n_total++;
        if ({state_o, Aluop, AluSrcA, AluSrcB} !== 9'b0001_11_0_11)
            $display("FAIL r_decode: got %b want 000111011",
                     {state_o, Aluop, AluSrcA, AluSrcB});
        else n_pass++;
        step();
        n_total++;
        if ({state_o, Aluop, AluSrcA, AluSrcB, RegWrite} !== 10'b0110_00_1_00_0)
            $display("FAIL r_exec: got %b want 0110001000",
                     {state_o, Aluop, AluSrcA, AluSrcB, RegWrite});
        else n_pass++;
        step();
        n_total++;
        if ({state_o, Aluop, RegWrite, RegDst, MemtoReg} !== 9'b0111_00_1_1_0)
            $display("FAIL r_wb: got %b want 011100110",
                     {state_o, Aluop, RegWrite, RegDst, MemtoReg});
        else n_pass++;
        step();
        n_total++;
        if (state_o !== 4'd0)
            $display("FAIL r_return: got %0d want 0", state_o);
        else n_pass++;
    endtask

    task automatic test_lw_wait();
        int cyc, rw, m2r, mw, br, to;
        run_instr(6'b100011, 1'b0, 3, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 8) $display("FAIL lw_cycles: got %0d want 8", cyc);
        else n_pass++;
        n_total++;
        if (m2r !== 1 || rw !== 1)
            $display("FAIL lw_wb: got rw=%0d m2r=%0d want 1 1", rw, m2r);
        else n_pass++;
        run_instr(6'b100011, 1'b0, 15, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 20 || to !== 0 || m2r !== 1)
            $display("FAIL lw_ready_at_max: got cyc=%0d to=%0d m2r=%0d want 20 0 1",
                     cyc, to, m2r);
        else n_pass++;
    endtask

    task automatic test_sw_addi();
        int cyc, rw, m2r, mw, br, to;
        run_instr(6'b101011, 1'b0, 0, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 4 || mw !== 1 || rw !== 0)
            $display("FAIL sw: got cyc=%0d mw=%0d rw=%0d want 4 1 0", cyc, mw, rw);
        else n_pass++;
        run_instr(6'b001000, 1'b0, 0, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 4 || rw !== 1 || m2r !== 0)
            $display("FAIL addi: got cyc=%0d rw=%0d m2r=%0d want 4 1 0", cyc, rw, m2r);
        else n_pass++;
        run_instr(6'b101011, 1'b0, 16, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 19 || to !== 1)
            $display("FAIL sw_timeout: got cyc=%0d to=%0d want 19 1", cyc, to);
        else n_pass++;
    endtask

    task automatic test_beq();
        int cyc, rw, m2r, mw, br, to;
        Opcode = 6'b000100; Zero = 1'b1; mem_ready = 1'b1;
        step();
        step();
        n_total++;
        if ({state_o, PCWriteBr, Aluop} !== 7'b1000_1_01)
            $display("FAIL beq_taken: got %b want 1000101",
                     {state_o, PCWriteBr, Aluop});
        else n_pass++;
        Zero = 1'b0;
        #1;
        n_total++;
        if (PCWriteBr !== 1'b0)
            $display("FAIL beq_zero_gate: got %b want 0", PCWriteBr);
        else n_pass++;
        step();
        run_instr(6'b000100, 1'b0, 0, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 3 || br !== 0)
            $display("FAIL beq_not_taken: got cyc=%0d br=%0d want 3 0", cyc, br);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int cyc, rw, m2r, mw, br, to;
        Opcode = 6'b111111; mem_ready = 1'b1;
        step();
        n_total++;
        if ({state_o, illegal} !== 5'b0001_1)
            $display("FAIL ill_pulse: got %b want 00011", {state_o, illegal});
        else n_pass++;
        step();
        n_total++;
        if ({state_o, illegal} !== 5'b0000_0)
            $display("FAIL ill_next: got %b want 00000", {state_o, illegal});
        else n_pass++;
        run_instr(6'b111111, 1'b1, 0, cyc, rw, m2r, mw, br, to);
        n_total++;
        if (cyc !== 2 || rw !== 0 || mw !== 0 || br !== 0)
            $display("FAIL ill_effects: got cyc=%0d rw=%0d mw=%0d br=%0d want 2 0 0 0",
                     cyc, rw, mw, br);
        else n_pass++;
    endtask

    task automatic test_fetch_timeout();
        int first_to;
        int n_wr;
        first_to = -1;
        n_wr = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_wr += int'(IRWrite || PCWrite);
            if (timeout) begin
                first_to = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_total++;
        if (first_to !== 15)
            $display("FAIL to_cycle: got %0d want 15", first_to);
        else n_pass++;
        n_total++;
        if (n_wr !== 0)
            $display("FAIL to_no_write: got %0d want 0", n_wr);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({state_o, timeout, MemRead} !== 6'b0000_0_1)
            $display("FAIL to_refetch: got %b want 000001",
                     {state_o, timeout, MemRead});
        else n_pass++;
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_write();
        Opcode = 6'b101011; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        n_total++;
        if ({state_o, MemWrite} !== 5'b0101_1)
            $display("FAIL mw_active: got %b want 01011", {state_o, MemWrite});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({state_o, MemWrite} !== 5'b0000_0)
            $display("FAIL mw_async_drop: got %b want 00000", {state_o, MemWrite});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        Opcode = 6'd0;
        #1;
        n_total++;
        if ({state_o, MemRead} !== 5'b0000_1)
            $display("FAIL rst_resume: got %b want 00001", {state_o, MemRead});
        else n_pass++;
        step();
        n_total++;
        if (state_o !== 4'd1)
            $display("FAIL rst_first_edge: got %0d want 1", state_o);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_addi();
        test_beq();
        test_illegal();
        test_fetch_timeout();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
